// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation encodings for the execute stage and decoder
package alu_pkg;

  localparam int ALUCTRL_WIDTH = 4;

  // Encoding is {funct7[5], funct3}
  typedef enum logic [ALUCTRL_WIDTH-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } aluctrl_e;

endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - combinational logarithmic barrel shifter for SLL/SRL/SRA
module alu_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shamt_i,
  input  logic             left_i,
  input  logic             arith_i,
  output logic [WIDTH-1:0] result_o
);

  logic [WIDTH-1:0] data_rev;
  logic [WIDTH-1:0] out_rev;
  logic [WIDTH-1:0] stg [0:SHW];
  logic             fill;

  // Left shifts reuse the right-shift network on bit-reversed data
  always_comb begin
    data_rev = '0;
    out_rev  = '0;
    for (int k = 0; k < WIDTH; k++) begin
      data_rev[k] = data_i[WIDTH-1-k];
      out_rev[k]  = stg[SHW][WIDTH-1-k];
    end
  end

  assign fill   = arith_i & ~left_i & data_i[WIDTH-1];
  assign stg[0] = left_i ? data_rev : data_i;

  for (genvar i = 0; i < SHW; i++) begin : g_stage
    localparam int N = 2 ** i;
    assign stg[i+1] = shamt_i[i] ? {{N{fill}}, stg[i][WIDTH-1:N]} : stg[i];
  end

  assign result_o = left_i ? out_rev : stg[SHW];

endmodule

// File: rtl/riscv_alu.sv
// rtl/riscv_alu.sv - RV32I ALU with registered result; ALU_ZERO_FLAG_EN adds a registered zero flag
module riscv_alu #(
  parameter int XLEN          = 32,
  parameter int ALUCTRL_WIDTH = alu_pkg::ALUCTRL_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [XLEN-1:0]          alu_a_i,
  input  logic [XLEN-1:0]          alu_b_i,
  input  logic [ALUCTRL_WIDTH-1:0] aluctrl_ctrl_i,
  output logic [XLEN-1:0]          alu_out_o
`ifdef ALU_ZERO_FLAG_EN
  ,
  output logic                     alu_zero_o
`endif
);

  import alu_pkg::*;

  localparam int SHAMT_W = $clog2(XLEN);

  logic            is_sub;
  logic [XLEN-1:0] b_op;
  logic [XLEN-1:0] addsub;
  logic            lt_signed;
  logic            lt_unsigned;
  logic [XLEN-1:0] shift_res;
  logic            shift_left;
  logic            shift_arith;
  logic [XLEN-1:0] alu_out_d, alu_out_q;

  // Single adder: subtraction is a + ~b + 1
  assign is_sub      = (aluctrl_ctrl_i == ALU_SUB);
  assign b_op        = is_sub ? ~alu_b_i : alu_b_i;
  assign addsub      = alu_a_i + b_op + {{(XLEN-1){1'b0}}, is_sub};
  assign lt_signed   = $signed(alu_a_i) < $signed(alu_b_i);
  assign lt_unsigned = alu_a_i < alu_b_i;
  assign shift_left  = (aluctrl_ctrl_i == ALU_SLL);
  assign shift_arith = (aluctrl_ctrl_i == ALU_SRA);

  alu_shifter #(
    .WIDTH (XLEN),
    .SHW   (SHAMT_W)
  ) u_shifter (
    .data_i   (alu_a_i),
    .shamt_i  (alu_b_i[SHAMT_W-1:0]),
    .left_i   (shift_left),
    .arith_i  (shift_arith),
    .result_o (shift_res)
  );

  always_comb begin
    alu_out_d = '0;
    case (aluctrl_ctrl_i)
      ALU_ADD, ALU_SUB:          alu_out_d = addsub;
      ALU_SLT:                   alu_out_d = {{(XLEN-1){1'b0}}, lt_signed};
      ALU_SLTU:                  alu_out_d = {{(XLEN-1){1'b0}}, lt_unsigned};
      ALU_XOR:                   alu_out_d = alu_a_i ^ alu_b_i;
      ALU_OR:                    alu_out_d = alu_a_i | alu_b_i;
      ALU_AND:                   alu_out_d = alu_a_i & alu_b_i;
      ALU_SLL, ALU_SRL, ALU_SRA: alu_out_d = shift_res;
      default:                   alu_out_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) alu_out_q <= '0;
    else     alu_out_q <= alu_out_d;
  end

  assign alu_out_o = alu_out_q;

`ifdef ALU_ZERO_FLAG_EN
  logic alu_zero_d, alu_zero_q;

  assign alu_zero_d = (alu_out_d == '0);

  always_ff @(posedge clk) begin
    if (rst) alu_zero_q <= 1'b1;
    else     alu_zero_q <= alu_zero_d;
  end

  assign alu_zero_o = alu_zero_q;
`endif

endmodule

// File: tb/tb_riscv_alu.sv
// tb/tb_riscv_alu.sv - self-checking bench for riscv_alu: directed cases plus random back-to-back ops
module tb_riscv_alu;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [3:0]  ctrl;
  logic [31:0] alu_out;
  int          checks = 0;
  int          errors = 0;

`ifdef ALU_ZERO_FLAG_EN
  logic alu_zero;
  riscv_alu dut (
    .clk            (clk),
    .rst            (rst),
    .alu_a_i        (a),
    .alu_b_i        (b),
    .aluctrl_ctrl_i (ctrl),
    .alu_out_o      (alu_out),
    .alu_zero_o     (alu_zero)
  );
`else
  riscv_alu dut (
    .clk            (clk),
    .rst            (rst),
    .alu_a_i        (a),
    .alu_b_i        (b),
    .aluctrl_ctrl_i (ctrl),
    .alu_out_o      (alu_out)
  );
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                          input logic [3:0] op);
    int unsigned sh;
    sh = y % 32;
    case (op)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_SLT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      OP_SLTU: return (x < y) ? 32'd1 : 32'd0;
      OP_XOR:  return x ^ y;
      OP_OR:   return x | y;
      OP_AND:  return x & y;
      OP_SLL:  return x << sh;
      OP_SRL:  return x >> sh;
      OP_SRA:  return 32'($signed(x) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] exp);
    chk(tag, alu_out, exp);
`ifdef ALU_ZERO_FLAG_EN
    chk({tag, "_zero"}, {31'b0, alu_zero}, {31'b0, exp == 32'd0});
`endif
  endtask

  task automatic run(input string tag, input logic [31:0] x, input logic [31:0] y,
                     input logic [3:0] op, input logic [31:0] exp);
    a = x; b = y; ctrl = op;
    @(posedge clk); #1;
    chk_out(tag, exp);
  endtask

  logic [3:0]  ops [10];
  logic [31:0] exp_r;

  initial begin
    ops = '{OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_XOR, OP_OR, OP_AND, OP_SLL, OP_SRL, OP_SRA};

    // Reset dominates even with live operands present
    rst = 1'b1; a = 32'd5; b = 32'd7; ctrl = OP_ADD;
    @(posedge clk); #1;
    chk_out("reset", 32'd0);
    rst = 1'b0;
    run("add_5_7", 32'd5, 32'd7, OP_ADD, 32'd12);

    run("add_wrap",  32'hFFFF_FFFF, 32'd1, OP_ADD, 32'd0);
    run("sub_0_1",   32'd0, 32'd1, OP_SUB, 32'hFFFF_FFFF);
    run("sub_10_3",  32'd10, 32'd3, OP_SUB, 32'd7);
    run("slt_neg",   32'hFFFF_FFFF, 32'd1, OP_SLT, 32'd1);
    run("sltu_neg",  32'hFFFF_FFFF, 32'd1, OP_SLTU, 32'd0);
    run("slt_eq",    32'd3, 32'd3, OP_SLT, 32'd0);
    run("sltu_msb",  32'd0, 32'h8000_0000, OP_SLTU, 32'd1);
    run("sll_4",     32'h8000_0001, 32'h0000_0024, OP_SLL, 32'h0000_0010);
    run("srl_4",     32'h8000_0001, 32'h0000_0024, OP_SRL, 32'h0800_0000);
    run("sra_4",     32'h8000_0001, 32'h0000_0024, OP_SRA, 32'hF800_0000);
    run("sll_0",     32'h8000_0001, 32'hFFFF_FFE0, OP_SLL, 32'h8000_0001);
    run("srl_0",     32'h8000_0001, 32'h0000_0000, OP_SRL, 32'h8000_0001);
    run("sra_0",     32'h8000_0001, 32'h0000_0020, OP_SRA, 32'h8000_0001);
    run("sra_31",    32'h8000_0000, 32'h0000_001F, OP_SRA, 32'hFFFF_FFFF);
    run("sll_31",    32'h0000_0003, 32'h0000_001F, OP_SLL, 32'h8000_0000);
    run("and",       32'hF0F0_00FF, 32'h0FF0_0F0F, OP_AND, 32'h00F0_000F);
    run("or",        32'hF0F0_00FF, 32'h0FF0_0F0F, OP_OR,  32'hFFF0_0FFF);
    run("xor",       32'hF0F0_00FF, 32'h0FF0_0F0F, OP_XOR, 32'hFF00_0FF0);
    run("undef_f",   32'hF0F0_00FF, 32'h0FF0_0F0F, 4'b1111, 32'd0);
    for (int u = 9; u <= 14; u++) begin
      if (u != 13) run("undef", $urandom, $urandom, 4'(u), 32'd0);
    end

    // Inputs changing between edges must not reach the output
    run("hold_pre", 32'd100, 32'd23, OP_ADD, 32'd123);
    a = 32'd1; b = 32'd1; ctrl = OP_SUB;
    #3;
    chk_out("hold_mid", 32'd123);

    // Mid-stream reset, then first edge after release computes normally
    rst = 1'b1; a = 32'd1; b = 32'd1; ctrl = OP_ADD;
    @(posedge clk); #1;
    chk_out("reset_mid", 32'd0);
    rst = 1'b0;
    run("post_reset", 32'd40, 32'd2, OP_ADD, 32'd42);

    // Back-to-back random operations, one result per edge
    for (int i = 0; i < 100; i++) begin
      a    = $urandom;
      b    = (i % 7 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      ctrl = ops[i % 10];
      if (i % 13 == 0) b = a;
      exp_r = ref_alu(a, b, ctrl);
      @(posedge clk); #1;
      chk_out("random", exp_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
